// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
//   N-channel H-bridge PWM driver for L293-style bridges. A free-running
//   period counter drives the PWM. Duty and direction commands are latched
//   into shadow registers only at period boundaries, so an update never cuts
//   a PWM pulse short. A direction reversal inserts DEADTIME cycles with the
//   enable held low. A per-channel brake forces a low-side brake until the
//   brake is released and the next boundary is reached.
//
//   Every output is registered from the next-cycle view of the counter and
//   the FSM. The value seen on a pin in a cycle therefore matches the counter
//   and channel state of that same cycle.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   sign[i]      direction command, 1 = forward (in_a=1, in_b=0)
//   duty         on-cycles per period, channel i at [i*DUTY_W +: DUTY_W]
//   brake[i]     brake request
//   enable_out   bridge enable (PWM)
//   in_a, in_b   bridge direction inputs
//   period_tick  one-cycle pulse while the counter is 0
//   debug_light  high while in reset, low after the first clock edge
module motor_pwm_driver #(
  parameter int NCH      = 2,
  parameter int DUTY_W   = 7,
  parameter int PERIOD   = 100,
  parameter int DEADTIME = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        sign,
  input  logic [NCH*DUTY_W-1:0] duty,
  input  logic [NCH-1:0]        brake,
  output logic [NCH-1:0]        enable_out,
  output logic [NCH-1:0]        in_a,
  output logic [NCH-1:0]        in_b,
  output logic                  period_tick,
  output logic                  debug_light
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SH_W  = $clog2(PERIOD + 1);
  localparam int DT_W  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [SH_W-1:0]  DUTY_MAX = SH_W'(PERIOD);
  localparam logic [DT_W-1:0]  DT_LAST  = DT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);

  typedef enum logic [1:0] {
    ST_DRIVE = 2'd0,
    ST_DEAD  = 2'd1,
    ST_BRAKE = 2'd2
  } state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boundary_s;
  logic             period_tick_q, period_tick_d;
  logic             debug_light_q, debug_light_d;

  logic [SH_W-1:0]  duty_sh_q [NCH];
  logic [SH_W-1:0]  duty_sh_d [NCH];
  logic [NCH-1:0]   sign_sh_q, sign_sh_d;
  logic [NCH-1:0]   cur_sign_q, cur_sign_d;
  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [DT_W-1:0]  dt_q [NCH];
  logic [DT_W-1:0]  dt_d [NCH];
  logic [NCH-1:0]   enable_q, enable_d;
  logic [NCH-1:0]   in_a_q, in_a_d;
  logic [NCH-1:0]   in_b_q, in_b_d;

  // Period counter, boundary detect and tick/debug next values.
  always_comb begin
    boundary_s = (cnt_q == CNT_LAST);
    if (boundary_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    period_tick_d = boundary_s;
    debug_light_d = 1'b0;
  end

  // Per-channel shadow latch, FSM next state and registered-output decode.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      duty_sh_d[i]  = duty_sh_q[i];
      sign_sh_d[i]  = sign_sh_q[i];
      state_d[i]    = state_q[i];
      cur_sign_d[i] = cur_sign_q[i];
      dt_d[i]       = {DT_W{1'b0}};
      enable_d[i]   = 1'b0;
      in_a_d[i]     = 1'b0;
      in_b_d[i]     = 1'b0;

      // Saturate so that an oversized command means "always on".
      if (boundary_s) begin
        if (32'(duty[i*DUTY_W +: DUTY_W]) > 32'(PERIOD)) begin
          duty_sh_d[i] = DUTY_MAX;
        end else begin
          duty_sh_d[i] = SH_W'(duty[i*DUTY_W +: DUTY_W]);
        end
        sign_sh_d[i] = sign[i];
      end else begin
        duty_sh_d[i] = duty_sh_q[i];
      end

      // Brake overrides everything, including a simultaneous sign change.
      if (brake[i]) begin
        state_d[i] = ST_BRAKE;
      end else begin
        case (state_q[i])
          ST_DRIVE: begin
            if (boundary_s && (sign[i] != cur_sign_q[i]) && (DEADTIME > 0)) begin
              state_d[i] = ST_DEAD;
            end else if (boundary_s) begin
              cur_sign_d[i] = sign[i];
            end else begin
              state_d[i] = ST_DRIVE;
            end
          end
          ST_DEAD: begin
            // Direction is re-taken from the shadow even if it did not change.
            if (dt_q[i] == DT_LAST) begin
              state_d[i]    = ST_DRIVE;
              cur_sign_d[i] = sign_sh_q[i];
            end else begin
              dt_d[i] = dt_q[i] + DT_W'(1);
            end
          end
          ST_BRAKE: begin
            if (boundary_s && (DEADTIME > 0)) begin
              state_d[i] = ST_DEAD;
            end else if (boundary_s) begin
              state_d[i]    = ST_DRIVE;
              cur_sign_d[i] = sign[i];
            end else begin
              state_d[i] = ST_BRAKE;
            end
          end
          default: begin
            state_d[i] = ST_DRIVE;
          end
        endcase
      end

      // Decode from next-cycle values so the pins line up with cnt/state.
      case (state_d[i])
        ST_DRIVE: begin
          enable_d[i] = (32'(cnt_d) < 32'(duty_sh_d[i]));
          in_a_d[i]   = cur_sign_d[i];
          in_b_d[i]   = ~cur_sign_d[i];
        end
        ST_DEAD: begin
          enable_d[i] = 1'b0;
          in_a_d[i]   = cur_sign_d[i];
          in_b_d[i]   = ~cur_sign_d[i];
        end
        ST_BRAKE: begin
          enable_d[i] = 1'b1;
          in_a_d[i]   = 1'b0;
          in_b_d[i]   = 1'b0;
        end
        default: begin
          enable_d[i] = 1'b0;
          in_a_d[i]   = 1'b0;
          in_b_d[i]   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= {CNT_W{1'b0}};
      period_tick_q <= 1'b0;
      debug_light_q <= 1'b1;
      sign_sh_q     <= {NCH{1'b0}};
      cur_sign_q    <= {NCH{1'b0}};
      enable_q      <= {NCH{1'b0}};
      in_a_q        <= {NCH{1'b0}};
      in_b_q        <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        duty_sh_q[i] <= {SH_W{1'b0}};
        state_q[i]   <= ST_DRIVE;
        dt_q[i]      <= {DT_W{1'b0}};
      end
    end else begin
      cnt_q         <= cnt_d;
      period_tick_q <= period_tick_d;
      debug_light_q <= debug_light_d;
      sign_sh_q     <= sign_sh_d;
      cur_sign_q    <= cur_sign_d;
      enable_q      <= enable_d;
      in_a_q        <= in_a_d;
      in_b_q        <= in_b_d;
      for (int i = 0; i < NCH; i++) begin
        duty_sh_q[i] <= duty_sh_d[i];
        state_q[i]   <= state_d[i];
        dt_q[i]      <= dt_d[i];
      end
    end
  end

  assign enable_out  = enable_q;
  assign in_a        = in_a_q;
  assign in_b        = in_b_q;
  assign period_tick = period_tick_q;
  assign debug_light = debug_light_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver (NCH=2, DUTY_W=7, PERIOD=100,
// DEADTIME=4). A cycle model pushes the expected pin vector into a queue at
// each rising edge; the vector is popped and compared on the falling edge.
// Directed checks count enable pulses over period-aligned windows.
module tb_motor_pwm_driver;

  localparam int NCH = 2;
  localparam int DUTY_W = 7;
  localparam int PERIOD = 100;
  localparam int DEADTIME = 4;
  localparam int DR = 0;
  localparam int DE = 1;
  localparam int BR = 2;

  logic                  clk;
  logic                  reset;
  logic [NCH-1:0]        sign;
  logic [NCH*DUTY_W-1:0] duty;
  logic [NCH-1:0]        brake;
  logic [NCH-1:0]        enable_out;
  logic [NCH-1:0]        in_a;
  logic [NCH-1:0]        in_b;
  logic                  period_tick;
  logic                  debug_light;

  motor_pwm_driver #(
    .NCH(NCH), .DUTY_W(DUTY_W), .PERIOD(PERIOD), .DEADTIME(DEADTIME)
  ) dut (
    .clk(clk), .reset(reset), .sign(sign), .duty(duty), .brake(brake),
    .enable_out(enable_out), .in_a(in_a), .in_b(in_b),
    .period_tick(period_tick), .debug_light(debug_light)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int hi0     = 0;
  int tk_cnt  = 0;
  logic [7:0] exp_q[$];

  // model state
  int m_cnt;
  int m_dsh[NCH];
  bit m_ssh[NCH];
  bit m_cur[NCH];
  int m_st[NCH];
  int m_dt[NCH];
  logic [NCH-1:0] m_en, m_a, m_b;
  logic m_tk, m_dbg;

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      m_dsh[i] = 0; m_ssh[i] = 1'b0; m_cur[i] = 1'b0; m_st[i] = DR; m_dt[i] = 0;
    end
    m_en = '0; m_a = '0; m_b = '0; m_tk = 1'b0; m_dbg = 1'b1;
  endtask

  task automatic model_edge();
    bit bnd;
    int ncnt;
    int nsh[NCH];
    int ns;
    int nd;
    int dv;
    bit nc;
    if (!reset) begin
      model_reset();
    end else begin
      bnd  = (m_cnt == PERIOD - 1);
      ncnt = bnd ? 0 : m_cnt + 1;
      for (int i = 0; i < NCH; i++) begin
        dv = int'(duty[i*DUTY_W +: DUTY_W]);
        nsh[i] = bnd ? ((dv > PERIOD) ? PERIOD : dv) : m_dsh[i];
      end
      for (int i = 0; i < NCH; i++) begin
        ns = m_st[i]; nc = m_cur[i]; nd = 0;
        if (brake[i]) ns = BR;
        else if (m_st[i] == DE) begin
          if (m_dt[i] == DEADTIME - 1) begin ns = DR; nc = m_ssh[i]; end
          else nd = m_dt[i] + 1;
        end
        else if (bnd && m_st[i] == BR) ns = DE;
        else if (bnd && sign[i] != m_cur[i]) ns = DE;
        else if (bnd) nc = sign[i];
        m_en[i] = (ns == BR) || (ns == DR && ncnt < nsh[i]);
        m_a[i]  = (ns != BR) && nc;
        m_b[i]  = (ns != BR) && !nc;
        m_st[i] = ns; m_cur[i] = nc; m_dt[i] = nd;
        if (bnd) m_ssh[i] = sign[i];
        m_dsh[i] = nsh[i];
      end
      m_tk = bnd; m_dbg = 1'b0; m_cnt = ncnt;
    end
  endtask

  task automatic step(input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_en, m_a, m_b, m_tk, m_dbg});
    @(negedge clk);
    got = {enable_out, in_a, in_b, period_tick, debug_light};
    exp = exp_q.pop_front();
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cnt=%0d observed=%b expected=%b", tag, m_cnt, got, exp);
    end
    hi0    += int'(enable_out[0]);
    tk_cnt += int'(period_tick);
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run_to(input int c, input string tag);
    int k = 0;
    while (m_cnt != c && k < 300) begin
      step(tag);
      k++;
    end
    check({tag, "_reach"}, m_cnt, c);
  endtask

  task automatic window(input string tag);
    hi0 = 0; tk_cnt = 0;
    repeat (PERIOD) step(tag);
  endtask

  initial begin
    reset = 1'b0; sign = '0; duty = '0; brake = '0;
    model_reset();
    repeat (3) step("in_reset");
    check("dbg_in_reset", int'(debug_light), 1);

    // duty0=50 forward, duty1=20 reverse
    duty[0 +: DUTY_W] = 7'd50; sign[0] = 1'b1;
    duty[DUTY_W +: DUTY_W] = 7'd20; sign[1] = 1'b0;
    reset = 1'b1;
    hi0 = 0;
    run_to(99, "first_period");
    check("hi0_before_boundary", hi0, 0);
    window("p1_dead");
    check("hi0_p1_dead", hi0, 50 - DEADTIME);
    window("p2_steady");
    check("hi0_duty50", hi0, 50);
    check("tick_per_period", tk_cnt, 1);
    check("in_a0_fwd", int'(in_a[0]), 1);
    check("in_b0_fwd", int'(in_b[0]), 0);
    check("dbg_after_rel", int'(debug_light), 0);

    // duty 0 then saturated 127
    duty[0 +: DUTY_W] = 7'd0;
    window("duty0");
    check("hi0_duty0", hi0, 0);
    duty[0 +: DUTY_W] = 7'd127;
    window("duty127");
    check("hi0_duty_sat", hi0, PERIOD);

    // reversal with duty 60
    duty[0 +: DUTY_W] = 7'd60;
    window("duty60");
    check("hi0_duty60", hi0, 60);
    run_to(40, "pre_rev");
    sign[0] = 1'b0;
    run_to(99, "rev_pending");
    check("in_a0_held", int'(in_a[0]), 1);
    window("rev_dead");
    check("hi0_rev", hi0, 60 - DEADTIME);
    check("in_a0_rev", int'(in_a[0]), 0);
    check("in_b0_rev", int'(in_b[0]), 1);

    // brake on channel 1
    run_to(37, "pre_brake");
    brake[1] = 1'b1;
    step("brake_on");
    check("brk_en1", int'(enable_out[1]), 1);
    check("brk_a1", int'(in_a[1]), 0);
    check("brk_b1", int'(in_b[1]), 0);
    run_to(80, "braking");
    brake[1] = 1'b0;
    run_to(99, "brake_hold");
    check("brk_hold_en1", int'(enable_out[1]), 1);
    step("brk_dead0");
    check("brk_dead_en1", int'(enable_out[1]), 0);
    check("brk_dead_b1", int'(in_b[1]), 1);
    repeat (3) step("brk_dead");
    check("brk_dead3_en1", int'(enable_out[1]), 0);
    step("brk_resume");
    check("brk_resume_en1", int'(enable_out[1]), 1);

    // async reset during DEAD
    sign[0] = 1'b1;
    run_to(99, "pre_dead2");
    step("dead2_a");
    step("dead2_b");
    #2 reset = 1'b0;
    #1 check("async_rst_pins", int'({enable_out, in_a, in_b, period_tick, debug_light}), 1);
    model_reset();
    @(negedge clk);
    repeat (2) step("rst_held");
    reset = 1'b1;
    hi0 = 0;
    run_to(99, "post_rst");
    check("hi0_post_rst", hi0, 0);
    repeat (PERIOD) step("settle");

    // duty 30 -> 70 changed at cnt 10
    duty[0 +: DUTY_W] = 7'd30;
    run_to(99, "pre30");
    hi0 = 0;
    run_to(10, "p30_a");
    duty[0 +: DUTY_W] = 7'd70;
    run_to(99, "p30_b");
    check("hi0_keep30", hi0, 30);
    window("p70");
    check("hi0_next70", hi0, 70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
